// File: rtl/mux_sel_dest.sv
// Destination-register selector: picks rt/rd (or r31 for links) and pipelines address + write-enable.
// Latency: output_dir is combinational; dest_q/wr_en_q lag by one cycle. Backpressure: stall holds, flush bubbles.
// Optional MUX_SEL_DEST_LINK_EN adds the link input that forces r31 (jal).
module mux_sel_dest (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    input  logic       sel_dest,
`ifdef MUX_SEL_DEST_LINK_EN
    input  logic       link,
`endif
    input  logic       reg_write,
    input  logic       stall,
    input  logic       flush,
    output logic [4:0] output_dir,
    output logic [4:0] dest_q,
    output logic       wr_en_q
);

    localparam logic [4:0] LINK_REG = 5'd31;

    logic wr_en_d;

    always_comb begin
        output_dir = sel_dest ? rd : rt;
`ifdef MUX_SEL_DEST_LINK_EN
        if (link) begin
            output_dir = LINK_REG;
        end
`endif
    end

    // $0 is hardwired; a write to it must never reach the register file.
    assign wr_en_d = reg_write && (output_dir != 5'd0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dest_q  <= 5'd0;
            wr_en_q <= 1'b0;
        end else if (!stall) begin
            dest_q  <= output_dir;
            wr_en_q <= wr_en_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_dest.sv
// Directed bench for mux_sel_dest: combinational select, reset, $0 suppression, stall/flush priority.
// Inputs change on the falling edge; registered outputs are sampled 1 ns after the rising edge.
module tb_mux_sel_dest;

    logic       clk;
    logic       rst;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       sel_dest;
`ifdef MUX_SEL_DEST_LINK_EN
    logic       link;
`endif
    logic       reg_write;
    logic       stall;
    logic       flush;
    logic [4:0] output_dir;
    logic [4:0] dest_q;
    logic       wr_en_q;

    int checks;
    int errors;

    mux_sel_dest dut (
        .clk        (clk),
        .rst        (rst),
        .rt         (rt),
        .rd         (rd),
        .sel_dest   (sel_dest),
`ifdef MUX_SEL_DEST_LINK_EN
        .link       (link),
`endif
        .reg_write  (reg_write),
        .stall      (stall),
        .flush      (flush),
        .output_dir (output_dir),
        .dest_q     (dest_q),
        .wr_en_q    (wr_en_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rt_v, input logic [4:0] rd_v, input logic sel_v,
                         input logic rw_v, input logic stall_v, input logic flush_v);
        @(negedge clk);
        rt        = rt_v;
        rd        = rd_v;
        sel_dest  = sel_v;
        reg_write = rw_v;
        stall     = stall_v;
        flush     = flush_v;
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        rt        = 5'h0F;
        rd        = 5'h0A;
        sel_dest  = 1'b0;
        reg_write = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
`ifdef MUX_SEL_DEST_LINK_EN
        link      = 1'b0;
`endif
        #1;
        // Combinational select works even while reset is held.
        check("comb_rt", output_dir, 5'h0F);
        sel_dest = 1'b1;
        #1;
        check("comb_rd", output_dir, 5'h0A);

        // Reset edge with a valid write pending.
        drive(5'h0F, 5'h0A, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("rst_dest", dest_q, 5'h00);
        check("rst_wr", wr_en_q, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_dest", dest_q, 5'h0A);
        check("post_rst_wr", wr_en_q, 1'b1);

        // Write to $0 is suppressed.
        drive(5'h00, 5'h0A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("zero_comb", output_dir, 5'h00);
        tick();
        check("zero_dest", dest_q, 5'h00);
        check("zero_wr", wr_en_q, 1'b0);

        // reg_write low with a non-zero address.
        drive(5'h0F, 5'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("nowr_dest", dest_q, 5'h0F);
        check("nowr_wr", wr_en_q, 1'b0);

        // Top register address.
        drive(5'h0F, 5'h1F, 1'b1, 1'b1, 1'b0, 1'b0);
        check("r31_comb", output_dir, 5'h1F);
        tick();
        check("r31_dest", dest_q, 5'h1F);

        // Load 0x0A then stall three edges with a new rd present.
        drive(5'h0F, 5'h0A, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("load_dest", dest_q, 5'h0A);
        for (int i = 0; i < 3; i++) begin
            drive(5'h0F, 5'h05, 1'b1, 1'b1, 1'b1, 1'b0);
            check("stall_comb", output_dir, 5'h05);
            tick();
            check("stall_dest", dest_q, 5'h0A);
            check("stall_wr", wr_en_q, 1'b1);
        end

        // Flush beats stall.
        drive(5'h0F, 5'h05, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("flush_stall_dest", dest_q, 5'h00);
        check("flush_stall_wr", wr_en_q, 1'b0);

        // Flush alone after a fresh load.
        drive(5'h0F, 5'h0C, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("reload_dest", dest_q, 5'h0C);
        drive(5'h0F, 5'h0C, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("flush_dest", dest_q, 5'h00);
        check("flush_wr", wr_en_q, 1'b0);

        // Reset during a stall clears; stall then holds the cleared value.
        drive(5'h0F, 5'h0A, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'h0F, 5'h05, 1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        check("rst_stall_dest", dest_q, 5'h00);
        check("rst_stall_wr", wr_en_q, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("hold_after_rst_dest", dest_q, 5'h00);
        drive(5'h0F, 5'h05, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("release_dest", dest_q, 5'h05);
        check("release_wr", wr_en_q, 1'b1);

`ifdef MUX_SEL_DEST_LINK_EN
        drive(5'h0F, 5'h0A, 1'b1, 1'b1, 1'b0, 1'b0);
        link = 1'b1;
        #1;
        check("link_comb", output_dir, 5'd31);
        tick();
        check("link_dest", dest_q, 5'd31);
        check("link_wr", wr_en_q, 1'b1);
        drive(5'h00, 5'h0A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("link_rt0_comb", output_dir, 5'd31);
        tick();
        check("link_rt0_wr", wr_en_q, 1'b1);
        @(negedge clk);
        link = 1'b0;
        #1;
        check("unlink_comb", output_dir, 5'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
